// File: rtl/mem_port_arbiter_if.sv
// Bundle of requester, memory and status signals around the shared memory port.
// slave modport is the arbiter's view; master modport is the hart/memory side.
// No logic lives here; timing is set entirely by mem_port_arbiter.
interface mem_port_arbiter_if;
  // instruction-fetch requester
  logic        i_if_req;
  logic [31:0] i_if_addr;
  logic        o_if_gnt;
  logic        o_if_rvalid;
  logic [31:0] o_if_rdata;
  // data (load/store) requester
  logic        i_dm_req;
  logic        i_dm_wen;
  logic [31:0] i_dm_addr;
  logic [31:0] i_dm_wdata;
  logic [3:0]  i_dm_mask;
  logic        o_dm_gnt;
  logic        o_dm_rvalid;
  logic [31:0] o_dm_rdata;
  // unified memory port
  logic        o_mem_req;
  logic        o_mem_wen;
  logic [31:0] o_mem_addr;
  logic [31:0] o_mem_wdata;
  logic [3:0]  o_mem_mask;
  logic        i_mem_gnt;
  logic        i_mem_rvalid;
  logic [31:0] i_mem_rdata;
  // status
  logic        o_busy;

  modport slave (
    input  i_if_req, i_if_addr,
    output o_if_gnt, o_if_rvalid, o_if_rdata,
    input  i_dm_req, i_dm_wen, i_dm_addr, i_dm_wdata, i_dm_mask,
    output o_dm_gnt, o_dm_rvalid, o_dm_rdata,
    output o_mem_req, o_mem_wen, o_mem_addr, o_mem_wdata, o_mem_mask,
    input  i_mem_gnt, i_mem_rvalid, i_mem_rdata,
    output o_busy
  );

  modport master (
    output i_if_req, i_if_addr,
    input  o_if_gnt, o_if_rvalid, o_if_rdata,
    output i_dm_req, i_dm_wen, i_dm_addr, i_dm_wdata, i_dm_mask,
    input  o_dm_gnt, o_dm_rvalid, o_dm_rdata,
    input  o_mem_req, o_mem_wen, o_mem_addr, o_mem_wdata, o_mem_mask,
    output i_mem_gnt, i_mem_rvalid, i_mem_rdata,
    input  o_busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one variable-latency memory port between fetch and data, data first, starvation-bounded.
// Latency: grant in cycle 0, o_mem_req cycle 1, requester rvalid one cycle after i_mem_rvalid (3 best case).
// Backpressure: one transaction outstanding; requesters hold req while busy, o_mem_* held until i_mem_gnt.
module mem_port_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input logic               i_clk,
  input logic               i_rst,
  mem_port_arbiter_if.slave bus
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             owner_dm;
  logic             if_gnt, dm_gnt;
  logic             starved;

  logic             mem_wen;
  logic [31:0]      mem_addr;
  logic [31:0]      mem_wdata;
  logic [3:0]       mem_mask;

  logic             if_rvalid, dm_rvalid;
  logic [31:0]      if_rdata, dm_rdata;

  // fetch has waited through STARVE_LIMIT data grants in a row
  assign starved = (cnt == CNT_W'(STARVE_LIMIT));

  // next state, one-hot grants and starvation counter update
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if_gnt    = 1'b0;
    dm_gnt    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.i_dm_req && !(bus.i_if_req && starved)) begin
          dm_gnt    = 1'b1;
          cnt_nxt   = bus.i_if_req ? cnt + CNT_W'(1) : '0;
          state_nxt = ISSUE;
        end else if (bus.i_if_req) begin
          if_gnt    = 1'b1;
          cnt_nxt   = '0;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        if (bus.i_mem_gnt) state_nxt = WAIT;
      end
      WAIT: begin
        if (bus.i_mem_rvalid) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // state and starvation counter registers
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // capture the granted request into the memory-side registers and remember its owner
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      owner_dm  <= 1'b0;
      mem_wen   <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_mask  <= '0;
    end else if (dm_gnt) begin
      owner_dm  <= 1'b1;
      mem_wen   <= bus.i_dm_wen;
      mem_addr  <= {bus.i_dm_addr[31:2], 2'b00};
      mem_wdata <= bus.i_dm_wdata;
      mem_mask  <= bus.i_dm_mask;
    end else if (if_gnt) begin
      owner_dm  <= 1'b0;
      mem_wen   <= 1'b0;
      mem_addr  <= {bus.i_if_addr[31:2], 2'b00};
      mem_wdata <= '0;
      mem_mask  <= 4'b1111;
    end
  end

  // route the response to its owner as a one-cycle pulse; responses outside WAIT are dropped
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      if_rvalid <= 1'b0;
      dm_rvalid <= 1'b0;
      if_rdata  <= '0;
      dm_rdata  <= '0;
    end else begin
      if_rvalid <= 1'b0;
      dm_rvalid <= 1'b0;
      if (state == WAIT && bus.i_mem_rvalid) begin
        if (owner_dm) begin
          dm_rvalid <= 1'b1;
          dm_rdata  <= mem_wen ? 32'h0 : bus.i_mem_rdata;
        end else begin
          if_rvalid <= 1'b1;
          if_rdata  <= bus.i_mem_rdata;
        end
      end
    end
  end

  assign bus.o_if_gnt    = if_gnt;
  assign bus.o_dm_gnt    = dm_gnt;
  assign bus.o_if_rvalid = if_rvalid;
  assign bus.o_if_rdata  = if_rdata;
  assign bus.o_dm_rvalid = dm_rvalid;
  assign bus.o_dm_rdata  = dm_rdata;
  assign bus.o_mem_req   = (state == ISSUE);
  assign bus.o_mem_wen   = mem_wen;
  assign bus.o_mem_addr  = mem_addr;
  assign bus.o_mem_wdata = mem_wdata;
  assign bus.o_mem_mask  = mem_mask;
  assign bus.o_busy      = (state != IDLE);

endmodule
